// File: rtl/ahb_bus_arbiter_if.sv
// Signal bundle for ahb_bus_arbiter: two AHB-lite master ports and one shared slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ahb_bus_arbiter_if;
  logic [1:0][31:0] s_m_haddr_i;
  logic [1:0][1:0]  s_m_htrans_i;
  logic [1:0]       s_m_hwrite_i;
  logic [1:0][2:0]  s_m_hsize_i;
  logic [1:0][2:0]  s_m_hburst_i;
  logic [1:0][3:0]  s_m_hprot_i;
  logic [1:0]       s_m_hmastlock_i;
  logic [1:0][5:0]  s_m_hparity_i;
  logic [1:0][31:0] s_m_hwdata_i;
  logic [1:0][6:0]  s_m_hwchecksum_i;
  logic [1:0]       s_m_hready_o;
  logic [1:0]       s_m_hresp_o;
  logic [31:0]      s_m_hrdata_o;
  logic [6:0]       s_m_hrchecksum_o;

  logic [31:0]      s_haddr_o;
  logic [1:0]       s_htrans_o;
  logic             s_hwrite_o;
  logic [2:0]       s_hsize_o;
  logic [2:0]       s_hburst_o;
  logic [3:0]       s_hprot_o;
  logic             s_hmastlock_o;
  logic [5:0]       s_hparity_o;
  logic [31:0]      s_hwdata_o;
  logic [6:0]       s_hwchecksum_o;
  logic [31:0]      s_hrdata_i;
  logic [6:0]       s_hrchecksum_i;
  logic             s_hready_i;
  logic             s_hresp_i;

  modport slave (
    input  s_m_haddr_i, s_m_htrans_i, s_m_hwrite_i, s_m_hsize_i, s_m_hburst_i,
           s_m_hprot_i, s_m_hmastlock_i, s_m_hparity_i, s_m_hwdata_i, s_m_hwchecksum_i,
           s_hrdata_i, s_hrchecksum_i, s_hready_i, s_hresp_i,
    output s_m_hready_o, s_m_hresp_o, s_m_hrdata_o, s_m_hrchecksum_o,
           s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o,
           s_hmastlock_o, s_hparity_o, s_hwdata_o, s_hwchecksum_o
  );

  modport master (
    output s_m_haddr_i, s_m_htrans_i, s_m_hwrite_i, s_m_hsize_i, s_m_hburst_i,
           s_m_hprot_i, s_m_hmastlock_i, s_m_hparity_i, s_m_hwdata_i, s_m_hwchecksum_i,
           s_hrdata_i, s_hrchecksum_i, s_hready_i, s_hresp_i,
    input  s_m_hready_o, s_m_hresp_o, s_m_hrdata_o, s_m_hrchecksum_o,
           s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o,
           s_hmastlock_o, s_hparity_o, s_hwdata_o, s_hwchecksum_o
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-lite arbiter (master 0 = instruction bus, master 1 = data bus) onto one slave port.
// Optional macro ARB_ROUND_ROBIN_EN: conflicts go to the master that was not granted last.
module ahb_bus_arbiter #(
  parameter int unsigned PRIO_MASTER = 1
) (
  input  logic             s_clk_i,
  input  logic             s_reset_i,
  ahb_bus_arbiter_if.slave bus
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [5:0]  hparity;
  } addr_phase_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  addr_phase_t pend_q [2];
  addr_phase_t pend_d [2];
  logic [1:0]  pend_v_q, pend_v_d;
  owner_e      dph_own_q, dph_own_d;
  logic        dph_lock_q, dph_lock_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_gnt_q, last_gnt_d;
`endif

  addr_phase_t live [2];
  addr_phase_t cand [2];
  logic [1:0]  own_m;
  logic [1:0]  m_hready;
  logic [1:0]  live_req;
  logic [1:0]  elig;
  logic        lock_act;
  logic        tie_winner;
  logic        win_v;
  logic        win;

  // State register: pending buffers, data-phase owner and its lock flag.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      pend_v_q   <= '0;
      pend_q[0]  <= '0;
      pend_q[1]  <= '0;
      dph_own_q  <= OWN_NONE;
      dph_lock_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      pend_v_q   <= pend_v_d;
      pend_q[0]  <= pend_d[0];
      pend_q[1]  <= pend_d[1];
      dph_own_q  <= dph_own_d;
      dph_lock_q <= dph_lock_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      live[m].haddr     = bus.s_m_haddr_i[m];
      live[m].htrans    = bus.s_m_htrans_i[m];
      live[m].hwrite    = bus.s_m_hwrite_i[m];
      live[m].hsize     = bus.s_m_hsize_i[m];
      live[m].hburst    = bus.s_m_hburst_i[m];
      live[m].hprot     = bus.s_m_hprot_i[m];
      live[m].hmastlock = bus.s_m_hmastlock_i[m];
      live[m].hparity   = bus.s_m_hparity_i[m];
    end
  end

  // A master only sees hready=1 when its previous address phase has been accepted or buffered.
  always_comb begin
    own_m[0] = (dph_own_q == OWN_M0);
    own_m[1] = (dph_own_q == OWN_M1);
    lock_act = dph_lock_q && (dph_own_q != OWN_NONE);
    for (int m = 0; m < 2; m++) begin
      m_hready[m] = own_m[m] ? bus.s_hready_i : ~pend_v_q[m];
      live_req[m] = live[m].htrans[1] & m_hready[m];
      cand[m]     = pend_v_q[m] ? pend_q[m] : live[m];
      elig[m]     = (pend_v_q[m] | live_req[m]) & (~lock_act | own_m[m])
                    & bus.s_hready_i & ~s_reset_i;
    end
`ifdef ARB_ROUND_ROBIN_EN
    tie_winner = ~last_gnt_q;
`else
    tie_winner = (PRIO_MASTER != 0);
`endif
    win_v = |elig;
    win   = (elig == 2'b11) ? tie_winner : elig[1];
  end

  // Next-state: grant on hready, capture every live request that did not win.
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_d[0]  = pend_q[0];
    pend_d[1]  = pend_q[1];
    dph_own_d  = dph_own_q;
    dph_lock_d = dph_lock_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_d = last_gnt_q;
`endif
    if (bus.s_hready_i) begin
      dph_own_d  = OWN_NONE;
      dph_lock_d = 1'b0;
      if (win_v) begin
        dph_own_d      = win ? OWN_M1 : OWN_M0;
        dph_lock_d     = cand[win].hmastlock;
        pend_v_d[win]  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt_d     = win;
`endif
      end
    end
    for (int m = 0; m < 2; m++) begin
      if (live_req[m] && !(win_v && (win == m[0]))) begin
        pend_v_d[m] = 1'b1;
        pend_d[m]   = live[m];
      end
    end
  end

  // Outputs: winner's address phase to the slave, data phase routed by the current owner.
  always_comb begin
    bus.s_haddr_o     = cand[win].haddr;
    bus.s_htrans_o    = win_v ? cand[win].htrans : HTRANS_IDLE;
    bus.s_hwrite_o    = cand[win].hwrite;
    bus.s_hsize_o     = cand[win].hsize;
    bus.s_hburst_o    = cand[win].hburst;
    bus.s_hprot_o     = cand[win].hprot;
    bus.s_hmastlock_o = cand[win].hmastlock;
    bus.s_hparity_o   = cand[win].hparity;

    bus.s_hwdata_o     = '0;
    bus.s_hwchecksum_o = '0;
    case (dph_own_q)
      OWN_M0: begin
        bus.s_hwdata_o     = bus.s_m_hwdata_i[0];
        bus.s_hwchecksum_o = bus.s_m_hwchecksum_i[0];
      end
      OWN_M1: begin
        bus.s_hwdata_o     = bus.s_m_hwdata_i[1];
        bus.s_hwchecksum_o = bus.s_m_hwchecksum_i[1];
      end
      default: ;
    endcase

    bus.s_m_hready_o     = s_reset_i ? 2'b11 : m_hready;
    bus.s_m_hresp_o      = s_reset_i ? 2'b00 : (own_m & {2{bus.s_hresp_i}});
    bus.s_m_hrdata_o     = bus.s_hrdata_i;
    bus.s_m_hrchecksum_o = bus.s_hrchecksum_i;
  end

endmodule
